// File: rtl/arduino_port_responder_pkg.sv
// Shared constants and state types for the Arduino req/ack byte port:
// register addresses, STATUS bit layout and the RX/TX FSM encodings.
package arduino_port_responder_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  // STATUS read layout: rx_count in [2:0], then the flags above it.
  localparam int STAT_CNT_W    = 3;
  localparam int STAT_OVF_BIT  = 3;
  localparam int STAT_DROP_BIT = 4;
  localparam int STAT_BUSY_BIT = 5;

  // STATUS write: write-one-to-clear bits.
  localparam int CLR_OVF_BIT  = 0;
  localparam int CLR_DROP_BIT = 1;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_REL
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic busy,
                                              input logic ovf,
                                              input logic drop);
    logic [31:0] s;
    s = '0;
    s[STAT_CNT_W-1:0] = cnt;
    s[STAT_BUSY_BIT]  = busy;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_DROP_BIT]  = drop;
    return s;
  endfunction

endpackage

// File: rtl/arduino_port_responder_if.sv
// CPU memory-mapped I/O bus as seen by the Arduino port block.
interface arduino_port_responder_if;
  logic        we;
  logic        re;
  logic        addr;
  logic [31:0] module_input;
  logic [31:0] module_output;

  modport master (output we, re, addr, module_input, input module_output);
  modport slave  (input we, re, addr, module_input, output module_output);
endinterface

// File: rtl/arduino_port_responder_byte_fifo.sv
// Small byte FIFO; a push while full only lands when a pop happens on the
// same edge, and a pop while empty is ignored.
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    // NOTE: pointers wrap for free because DEPTH is a power of two.
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/arduino_port_responder.sv
// Four-phase req/ack byte port between the CPU I/O bus and an Arduino:
// RX responder feeding a FIFO, TX initiator driven by CPU writes.
module arduino_port_responder
  import arduino_port_responder_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  arduino_port_responder_if.slave  bus,
  input  logic [7:0]               ard_data_in,
  input  logic                     ard_req_in,
  output logic                     ard_ack_out,
  output logic [7:0]               ard_data_out,
  output logic                     ard_req_out,
  input  logic                     ard_ack_in
);

  localparam int CW = $clog2(DEPTH) + 1;

  rx_state_e              rx_state_q, rx_state_d;
  tx_state_e              tx_state_q, tx_state_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   rx_overflow_q, rx_overflow_d;
  logic                   tx_drop_q, tx_drop_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

  logic          req_s, ack_s;
  logic          wr_data, wr_stat, rd_data;
  logic          tx_busy, push, pop;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] rx_count;
  logic          unused_input_bits;

  assign req_s   = req_sync_q[SYNC_STAGES-1];
  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  assign wr_data = bus.we && (bus.addr == ADDR_DATA);
  assign wr_stat = bus.we && (bus.addr == ADDR_STATUS);
  assign rd_data = bus.re && (bus.addr == ADDR_DATA);
  assign pop     = rd_data && !fifo_empty;
  assign push    = (rx_state_q == R_IDLE) && req_s;
  assign tx_busy = (tx_state_q != T_IDLE);
  assign unused_input_bits = ^bus.module_input[31:8];

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ard_data_in),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  always_comb begin
    req_sync_d    = {req_sync_q[SYNC_STAGES-2:0], ard_req_in};
    ack_sync_d    = {ack_sync_q[SYNC_STAGES-2:0], ard_ack_in};
    rx_state_d    = rx_state_q;
    tx_state_d    = tx_state_q;
    tx_data_d     = tx_data_q;
    rx_overflow_d = rx_overflow_q;
    tx_drop_d     = tx_drop_q;

    // Clears first so a same-cycle set event is never lost.
    if (wr_stat && bus.module_input[CLR_OVF_BIT])  rx_overflow_d = 1'b0;
    if (wr_stat && bus.module_input[CLR_DROP_BIT]) tx_drop_d     = 1'b0;

    unique case (rx_state_q)
      R_IDLE: if (req_s) begin
        if (fifo_full && !pop) rx_overflow_d = 1'b1;
        rx_state_d = R_ACK;
      end
      R_ACK:  if (!req_s) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase

    unique case (tx_state_q)
      T_IDLE: if (wr_data) begin
        tx_data_d  = bus.module_input[7:0];
        tx_state_d = T_REQ;
      end
      T_REQ:  if (ack_s)  tx_state_d = T_REL;
      T_REL:  if (!ack_s) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase

    if (wr_data && tx_busy) tx_drop_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= R_IDLE;
      tx_state_q    <= T_IDLE;
      tx_data_q     <= '0;
      rx_overflow_q <= 1'b0;
      tx_drop_q     <= 1'b0;
      req_sync_q    <= '0;
      ack_sync_q    <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      tx_state_q    <= tx_state_d;
      tx_data_q     <= tx_data_d;
      rx_overflow_q <= rx_overflow_d;
      tx_drop_q     <= tx_drop_d;
      req_sync_q    <= req_sync_d;
      ack_sync_q    <= ack_sync_d;
    end
  end

  assign ard_ack_out  = (rx_state_q == R_ACK);
  assign ard_req_out  = (tx_state_q == T_REQ);
  assign ard_data_out = tx_data_q;

  always_comb begin
    bus.module_output = '0;
    if (bus.addr == ADDR_STATUS)
      bus.module_output = pack_status(STAT_CNT_W'(rx_count), tx_busy,
                                      rx_overflow_q, tx_drop_q);
    else if (!fifo_empty)
      bus.module_output = {24'b0, fifo_head};
  end

endmodule
